dcm_drp_ctrl: RTL

- Sequences runtime reconfiguration of the Global Controller DCM_ADV CLKFX synthesiser over its DRP port: M/D write, optional readback check, DCM reset, wait for lock.
- Sits between the controller's configuration registers and the DCM wrapper's daddr/di/den/dwe/dout/drdy/rst_in/locked_out pins.
- Runs on the DRP clock (dclk).
- Only one reconfiguration is in flight at a time; the requester gets a done pulse plus a status code.

---
 rtl/dcm_drp_ctrl_if.sv | 22 ++
 rtl/dcm_drp_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dcm_drp_ctrl_if.sv
// DRP and DCM control pins between the reconfiguration controller
// and the DCM_ADV wrapper.
interface dcm_drp_ctrl_if;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        dcm_rst;
    logic        dcm_locked;

    modport master (
        output den, dwe, daddr, di, dcm_rst,
        input  dout, drdy, dcm_locked
    );

    modport slave (
        input  den, dwe, daddr, di, dcm_rst,
        output dout, drdy, dcm_locked
    );
endinterface

// File: rtl/dcm_drp_ctrl.sv
// CLKFX M/D reconfiguration sequencer: DRP write, optional readback,
// DCM reset hold and lock wait, with a one-shot done/status report.
module dcm_drp_ctrl #(
    parameter logic [6:0] DRP_ADDR     = 7'h50,
    parameter int         RST_PRE      = 16,
    parameter int         RST_POST     = 16,
    parameter int         DRDY_TIMEOUT = 64,
    parameter int         LOCK_TIMEOUT = 1000000,
    parameter bit         READBACK     = 1'b1
) (
    input  logic       dclk,
    input  logic       rst_in,
    input  logic       req,
    input  logic [5:0] mult,
    input  logic [5:0] div,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    dcm_drp_ctrl_if.master drp
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_WR, S_WRDY, S_RD,
        S_RRDY, S_POST, S_LOCK, S_FIN
    } state_e;

    localparam logic [23:0] PRE_LAST  = 24'(RST_PRE - 1);
    localparam logic [23:0] POST_LAST = 24'(RST_POST - 1);
    localparam logic [23:0] DRDY_LAST = 24'(DRDY_TIMEOUT - 1);
    localparam logic [23:0] LOCK_LAST = 24'(LOCK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  status_q, status_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        rst_q, rst_d;
    logic        param_ok;

    assign param_ok = (mult >= 6'd2) && (mult <= 6'd32) &&
                      (div >= 6'd1) && (div <= 6'd32);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 24'd1;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        status_d = status_q;
        den_d    = 1'b0;
        dwe_d    = 1'b0;
        daddr_d  = daddr_q;
        di_d     = di_q;
        rst_d    = rst_q;
        unique case (state_q)
            S_IDLE: begin
                rst_d  = 1'b0;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (req) begin
                    wdata_d = {2'b00, mult - 6'd1, 2'b00, div - 6'd1};
                    if (!param_ok) begin
                        status_d = 3'd1;
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        status_d = 3'd0;
                        busy_d   = 1'b1;
                        rst_d    = 1'b1;
                        state_d  = S_PRE;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    daddr_d = DRP_ADDR;
                    di_d    = wdata_q;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                cnt_d   = '0;
                state_d = S_WRDY;
            end
            S_WRDY: begin
                // drdy on the timeout cycle still counts as success
                if (drp.drdy) begin
                    cnt_d = '0;
                    if (READBACK) begin
                        den_d   = 1'b1;
                        daddr_d = DRP_ADDR;
                        state_d = S_RD;
                    end else begin
                        state_d = S_POST;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    if (status_q == 3'd0) status_d = 3'd2;
                    cnt_d   = '0;
                    state_d = S_POST;
                end
            end
            S_RD: begin
                cnt_d   = '0;
                state_d = S_RRDY;
            end
            S_RRDY: begin
                if (drp.drdy) begin
                    if (drp.dout != wdata_q && status_q == 3'd0)
                        status_d = 3'd3;
                    cnt_d   = '0;
                    state_d = S_POST;
                end else if (cnt_q == DRDY_LAST) begin
                    if (status_q == 3'd0) status_d = 3'd2;
                    cnt_d   = '0;
                    state_d = S_POST;
                end
            end
            S_POST: begin
                if (cnt_q == POST_LAST) begin
                    rst_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (drp.dcm_locked) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end else if (cnt_q == LOCK_LAST) begin
                    if (status_q == 3'd0) status_d = 3'd4;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= 3'd0;
            den_q    <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            di_q     <= '0;
            rst_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
            den_q    <= den_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            di_q     <= di_d;
            rst_q    <= rst_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;
    assign drp.den     = den_q;
    assign drp.dwe     = dwe_q;
    assign drp.daddr   = daddr_q;
    assign drp.di      = di_q;
    assign drp.dcm_rst = rst_q;

endmodule
